// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with max-hold timeout; define RR_ARBITER_LOCK_EN to let lock extend a grant past MAX_HOLD.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 lock,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 any_req,
  output logic                 timeout
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MX   = CW'(MAX_HOLD);
  localparam logic [IW:0]   NN   = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d, ptr_q, ptr_d, win, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, timeout_q, timeout_d, ext;
  logic [IW:0]   s;
`ifdef RR_ARBITER_LOCK_EN
  assign ext = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign ext = 1'b0;
`endif
  assign any_req = |req;
  // descending scan so the closest index above ptr is the last one written
  always_comb begin
    win = '0;
    s   = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s   = {1'b0, ptr_q} + (IW+1)'(k);
      idx = IW'(s >= NN ? s - NN : s);
      if (req[idx]) win = idx;
    end
  end
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (any_req) begin
        state_d  = GRANT;
        gnt_d    = ONE << win;
        gnt_id_d = win;
        ptr_d    = win == LAST ? '0 : win + 1'b1;
        cnt_d    = CW'(1);
      end
    end else if (!req[gnt_id_q] || (cnt_q == MX && !ext)) begin
      state_d   = IDLE;
      gnt_d     = '0;
      gnt_id_d  = '0;
      cnt_d     = '0;
      timeout_d = req[gnt_id_q];
    end else begin
      cnt_d = cnt_q == MX ? cnt_q : cnt_q + 1'b1;
    end
    busy_d = state_d == GRANT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: vector table, directed sequences and random traffic against a behavioural model.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
`ifdef RR_ARBITER_LOCK_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, lock = 1'b0;
  logic [N-1:0] req = '0, gnt;
  logic [1:0] gnt_id;
  logic busy, any_req, timeout;
  int n_cmp = 0, n_bad = 0;
  int m_own = -1, m_held = 0, m_ptr = 0, n_to = 0;
  bit m_to = 1'b0;
  typedef struct {
    logic [3:0] r;
    logic       l, rs;
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .any_req(any_req), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // owner = granted requester (-1 idle), held = cycles owned so far
  task automatic model();
    m_to = 1'b0;
    if (rst) begin
      m_own = -1; m_held = 0; m_ptr = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      if (m_own >= 0) begin
        m_held = 1;
        m_ptr  = (m_own + 1) % N;
      end
    end else if (!req[m_own]) begin
      m_own = -1;
    end else if (m_held >= MH && !(LE && lock)) begin
      m_own = -1;
      m_to  = 1'b1;
    end else if (m_held < MH) begin
      m_held++;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic l, input logic rs);
    req = r; lock = l; rst = rs;
    #1;
    chk("any_req", any_req, |r);
    @(posedge clk);
    model();
    #1;
    chk("gnt", gnt, m_own < 0 ? 0 : 1 << m_own);
    chk("gnt_id", gnt_id, m_own < 0 ? 0 : m_own);
    chk("busy", busy, m_own >= 0);
    chk("timeout", timeout, m_to);
    chk("onehot", $countones(gnt) <= 1, 1);
    if (timeout === 1'b1) n_to++;
  endtask

  initial begin
    tbl.push_back('{4'b0000, 0, 1, 4'b0000, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'b0100, 0, 0, 4'b0100, 2, 0});
    tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0});
    tbl.push_back('{4'b0101, 0, 0, 4'b0001, 0, 0});
    tbl.push_back('{4'b0101, 1, 0, 4'b0001, 0, 0});
    tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0});
    tbl.push_back('{4'b0010, 0, 1, 4'b0000, 0, 0});
    tbl.push_back('{4'b0011, 0, 0, 4'b0001, 0, 0});
    tbl.push_back('{4'b0011, 0, 0, 4'b0001, 0, 0});
    tbl.push_back('{4'b0010, 0, 0, 4'b0000, 0, 0});
    tbl.push_back('{4'b0010, 0, 0, 4'b0010, 1, 0});
    tbl.push_back('{4'b0010, 0, 1, 4'b0000, 0, 0});
    tbl.push_back('{4'b0011, 0, 0, 4'b0001, 0, 0});
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].l, tbl[i].rs);
      chk("tbl_gnt", gnt, tbl[i].g);
      chk("tbl_id", gnt_id, tbl[i].id);
      chk("tbl_busy", busy, tbl[i].g != 0);
      chk("tbl_to", timeout, tbl[i].to);
    end
    // all four requesting: 8-cycle grants rotating 0..3, each followed by one idle timeout cycle
    cyc('0, 0, 1);
    n_to = 0;
    for (int t = 1; t <= 45; t++) begin
      cyc(4'b1111, 0, 0);
      chk("rot_gnt", gnt, (t - 1) % 9 < 8 ? 1 << (((t - 1) / 9) % 4) : 0);
      chk("rot_to", timeout, (t - 1) % 9 == 8);
    end
    chk("rot_to_count", n_to, 5);
    // single locked requester
    cyc('0, 0, 1);
    for (int t = 1; t <= 20; t++) begin
      cyc(4'b0001, 1, 0);
      chk("lock_gnt", gnt, LE ? 1 : ((t - 1) % 9 < 8 ? 1 : 0));
      chk("lock_to", timeout, LE ? 0 : ((t - 1) % 9 == 8));
    end
    if (LE) begin
      cyc(4'b0001, 0, 0);
      chk("unlock_gnt", gnt, 0);
      chk("unlock_to", timeout, 1);
    end
    cyc('0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0 ? 4'b0000 : 4'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
